// File: rtl/keycode_rx_fifo_if.sv
// Avalon-MM slave bus bundle for keycode_rx_fifo: word address, strobes and data.
// The CPU or bus fabric side uses the master modport; the FIFO uses the slave modport.
interface keycode_rx_fifo_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output read_n,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  read_n,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/keycode_rx_fifo.sv
// Keycode receive FIFO: hardware pushes keycodes, the CPU pops them by reading DATA over Avalon-MM.
// Optional maskable interrupt is enabled by defining KEYCODE_RX_IRQ_EN.
module keycode_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   keycode_rx_fifo_if.slave  bus,
   input  logic [DATA_W-1:0] in_keycode,
   input  logic              in_valid,
   output logic              irq
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              rd, wr;
   logic              empty, full;
   logic              pop, push_ok, ovf_set;
   logic [DATA_W-1:0] head;
   logic [31:0]       irqmask_rd;
   logic [31:0]       rdata;

   assign rd    = bus.chipselect & ~bus.read_n;
   assign wr    = bus.chipselect & ~bus.write_n;
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the CPU pops in the same cycle.
   always_comb begin
      pop        = rd && (bus.address == ADDR_DATA) && !empty;
      push_ok    = in_valid && (!full || pop);
      ovf_set    = in_valid && full && !pop;

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Clear first so a simultaneous new overflow is not lost.
      if (wr && (bus.address == ADDR_STATUS) && bus.writedata[2]) begin
         overflow_d = 1'b0;
      end
      if (ovf_set) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= in_keycode;
      end
   end

`ifdef KEYCODE_RX_IRQ_EN
   logic [1:0] irq_mask_q, irq_mask_d;
   logic       irq_q, irq_d;
   logic       unused_wdata;

   always_comb begin
      irq_mask_d = irq_mask_q;
      if (wr && (bus.address == ADDR_IRQMASK)) begin
         irq_mask_d = bus.writedata[1:0];
      end
      irq_d = (irq_mask_q[0] && !empty) || (irq_mask_q[1] && overflow_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_q <= 2'b00;
         irq_q      <= 1'b0;
      end else begin
         irq_mask_q <= irq_mask_d;
         irq_q      <= irq_d;
      end
   end

   assign irqmask_rd   = {30'd0, irq_mask_q};
   assign irq          = irq_q;
   assign unused_wdata = ^bus.writedata[31:3];
`else
   logic unused_wdata;

   assign irqmask_rd   = 32'd0;
   assign irq          = 1'b0;
   assign unused_wdata = ^{bus.writedata[31:3], bus.writedata[1:0]};
`endif

   // Zero-latency read mux; the bus reads 0 whenever no read is in progress.
   always_comb begin
      rdata = 32'd0;
      if (rd) begin
         case (bus.address)
            ADDR_DATA: begin
               if (!empty) begin
                  rdata[DATA_W]     = 1'b1;
                  rdata[DATA_W-1:0] = head;
               end
            end
            ADDR_STATUS: begin
               rdata[0]         = empty;
               rdata[1]         = full;
               rdata[2]         = overflow_q;
               rdata[8 +: CNT_W] = count_q;
            end
            ADDR_IRQMASK: rdata = irqmask_rd;
            default:      rdata = 32'd0;
         endcase
      end
   end

   assign bus.readdata = rdata;

endmodule
